sbox_arbiter: RTL

Shares one byte-wide, pipelined S-box lookup unit between the key-expansion datapath and the SubBytes datapath. It accepts whole-word (4-byte) and whole-state (16-byte) substitution jobs and arbitrates between them at job boundaries using round-robin. Each job is streamed one byte per cycle into the shared S-box, and the returned bytes are reassembled into the result. It sits between the AES controller's keyexp/sbytes stages and the single S-box instance.

---
 rtl/aes_pkg.sv | 18 +
 rtl/sbox_arb_collect.sv | 35 +++
 rtl/sbox_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the S-box arbiter: FSM states, owner codes and job sizes in bytes.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic [1:0] OWN_NONE   = 2'b00;
   localparam logic [1:0] OWN_KEYEXP = 2'b01;
   localparam logic [1:0] OWN_SBYTES = 2'b10;

   localparam int KEYEXP_BYTES = 4;
   localparam int SBYTES_BYTES = 16;

endpackage

// File: rtl/sbox_arb_collect.sv
// Return-side reassembly: delays issue valid by SBOX_LAT and writes each returned byte MSB-first.
// Latency SBOX_LAT from issue to capture; no backpressure, the S-box pipeline never stalls.
module sbox_arb_collect
   import aes_pkg::*;
#(
   parameter int SBOX_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         issue_vld,
   input  logic [7:0]   sbox_out,
   output logic [127:0] asm_dat
);

   logic [SBOX_LAT-1:0] vld_q;
   logic [3:0]          rcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= '0;
         rcnt    <= '0;
         asm_dat <= '0;
      end else begin
         vld_q <= (vld_q << 1) | SBOX_LAT'(issue_vld);
         if (start) begin
            rcnt <= '0;
         end else if (vld_q[SBOX_LAT-1]) begin
            asm_dat[8*(SBYTES_BYTES-1-int'(rcnt)) +: 8] <= sbox_out;
            rcnt <= rcnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/sbox_arbiter.sv
// Round-robin share of one pipelined S-box between SubWord (4 B) and SubBytes (16 B) jobs; done N+1+SBOX_LAT
// cycles after grant, no backpressure (requests are held levels). Build option SBOX_ARBITER_ROTWORD_EN adds RotWord.
module sbox_arbiter
   import aes_pkg::*;
#(
   parameter int SBOX_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         keyexp_req,
   input  logic [31:0]  keyexp_word,
   output logic         keyexp_done,
   output logic [31:0]  keyexp_result,
   input  logic         sbytes_req,
   input  logic [127:0] sbytes_state,
   output logic         sbytes_done,
   output logic [127:0] sbytes_result,
   output logic [7:0]   sbox_in,
   output logic         sbox_valid,
   input  logic [7:0]   sbox_out,
   output logic [1:0]   owner,
   output logic         busy
);

   arb_state_t   state, state_nxt;
   logic [1:0]   grant, last_grant;
   logic [3:0]   cnt, last_idx;
   logic [127:0] job, asm_dat, sbytes_res_q;
   logic [31:0]  key_ord, keyexp_res_q;
   logic         start;

`ifdef SBOX_ARBITER_ROTWORD_EN
   assign key_ord = {keyexp_word[23:0], keyexp_word[31:24]};
`else
   assign key_ord = keyexp_word;
`endif

   assign last_idx = (owner == OWN_KEYEXP) ? 4'(KEYEXP_BYTES - 1) : 4'(SBYTES_BYTES - 1);
   assign start    = (grant != OWN_NONE);

   always_comb begin
      state_nxt = state;
      grant     = OWN_NONE;
      unique case (state)
         IDLE: begin
            if (keyexp_req && (!sbytes_req || last_grant == OWN_SBYTES))
               grant = OWN_KEYEXP;
            else if (sbytes_req)
               grant = OWN_SBYTES;
            if (grant != OWN_NONE)
               state_nxt = ISSUE;
         end
         ISSUE:   if (cnt == last_idx) state_nxt = DRAIN;
         DRAIN:   if (cnt == 4'(SBOX_LAT - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Jobs are stored left-justified so byte i always sits at the same position for both job sizes.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner        <= OWN_NONE;
         last_grant   <= OWN_SBYTES;
         cnt          <= '0;
         job          <= '0;
         keyexp_res_q <= '0;
         sbytes_res_q <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               owner <= grant;
               cnt   <= '0;
               job   <= (grant == OWN_KEYEXP) ? {key_ord, 96'd0} : sbytes_state;
            end
            ISSUE: cnt <= (cnt == last_idx) ? 4'd0 : cnt + 4'd1;
            DRAIN: cnt <= cnt + 4'd1;
            DONE: begin
               last_grant <= owner;
               owner      <= OWN_NONE;
               if (owner == OWN_KEYEXP) keyexp_res_q <= asm_dat[127:96];
               else                     sbytes_res_q <= asm_dat;
            end
            default: ;
         endcase
      end
   end

   assign sbox_valid    = (state == ISSUE);
   assign sbox_in       = sbox_valid ? job[8*(SBYTES_BYTES-1-int'(cnt)) +: 8] : 8'd0;
   assign keyexp_done   = (state == DONE) && (owner == OWN_KEYEXP);
   assign sbytes_done   = (state == DONE) && (owner == OWN_SBYTES);
   assign keyexp_result = keyexp_done ? asm_dat[127:96] : keyexp_res_q;
   assign sbytes_result = sbytes_done ? asm_dat : sbytes_res_q;
   assign busy          = (state != IDLE);

   sbox_arb_collect #(.SBOX_LAT(SBOX_LAT)) u_collect (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .issue_vld (sbox_valid),
      .sbox_out  (sbox_out),
      .asm_dat   (asm_dat)
   );

endmodule
